// File: rtl/chess_pkg.sv
// Shared constants for the chess-clock turn controller: FSM states, winner and player codes.
package chess_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } state_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic PL_ONE = 1'b0;
   localparam logic PL_TWO = 1'b1;

   // The player whose timer hit zero loses; both at once is a draw.
   function automatic logic [1:0] win_code(input logic z1, input logic z2);
      if (z1 && z2)
         return WIN_DRAW;
      else if (z1)
         return WIN_P2;
      else
         return WIN_P1;
   endfunction

endpackage

// File: rtl/chess_turn_ctrl_if.sv
// Button, timer-flag and control bundle between the turn controller and its environment.
interface chess_turn_ctrl_if #(parameter int MOVE_W = 6);

   logic              btn_p1;
   logic              btn_p2;
   logic              btn_go;
   logic              zero1;
   logic              zero2;
   logic              start;
   logic              player;
   logic [1:0]        winner;
   logic [1:0]        game_state;
   logic [MOVE_W-1:0] moves;

   modport master (
      input  btn_p1, btn_p2, btn_go, zero1, zero2,
      output start, player, winner, game_state, moves
   );

   modport slave (
      output btn_p1, btn_p2, btn_go, zero1, zero2,
      input  start, player, winner, game_state, moves
   );

endinterface

// File: rtl/btn_conditioner.sv
// Raw push-button -> 2-flop sync -> debounce -> registered one-cycle press pulse.
// Press appears DEBOUNCE_CYC+2 edges after the raw level is first sampled.
module btn_conditioner #(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   localparam logic [7:0] CYC = 8'(DEBOUNCE_CYC);

   logic       sync1_q, sync2_q;
   logic       lvl_q, lvl_d;
   logic       lvl_dly_q;
   logic       press_q;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] fill_q;

   // Once the synchroniser has refilled after reset, the level is adopted without
   // an edge, so a button held through reset never produces a press.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = 8'd0;
      if (fill_q == 2'd2) begin
         lvl_d = sync2_q;
      end else if (fill_q == 2'd3 && sync2_q != lvl_q) begin
         if (cnt_q + 8'd1 == CYC)
            lvl_d = ~lvl_q;
         else
            cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= 8'd0;
         lvl_q     <= 1'b0;
         lvl_dly_q <= 1'b0;
         press_q   <= 1'b0;
         fill_q    <= 2'd0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         lvl_q     <= lvl_d;
         lvl_dly_q <= (fill_q == 2'd2) ? sync2_q : lvl_q;
         press_q   <= lvl_q & ~lvl_dly_q;
         if (fill_q != 2'd3)
            fill_q <= fill_q + 2'd1;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/chess_turn_ctrl.sv
// Chess-clock game FSM: conditions buttons, drives timer start/player, ends game on zero flags.
// Optional move counter enabled by defining CHESS_MOVE_CNT_EN.
module chess_turn_ctrl
   import chess_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4,
   parameter int MOVE_W       = 6
) (
   input logic             clk_four,
   input logic             reset,
   chess_turn_ctrl_if.master bus
);

   logic   p1_ev, p2_ev, go_ev;
   logic   zero_hit, switch_d;
   state_e state_q;
   logic   start_q, player_q;
   logic [1:0] winner_q;

   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_p1 (
      .clk_i(clk_four), .rst_i(reset), .btn_i(bus.btn_p1), .press_o(p1_ev));
   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_p2 (
      .clk_i(clk_four), .rst_i(reset), .btn_i(bus.btn_p2), .press_o(p2_ev));
   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_go (
      .clk_i(clk_four), .rst_i(reset), .btn_i(bus.btn_go), .press_o(go_ev));

   assign zero_hit = (state_q == ST_RUN || state_q == ST_PAUSE) && (bus.zero1 || bus.zero2);

   // Only the active player's button may hand over the turn; zero and go outrank it.
   assign switch_d = (state_q == ST_RUN) && !zero_hit && !go_ev &&
                     ((player_q == PL_ONE && p1_ev) || (player_q == PL_TWO && p2_ev));

   always_ff @(posedge clk_four) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         player_q <= PL_ONE;
         winner_q <= WIN_NONE;
      end else if (zero_hit) begin
         state_q  <= ST_OVER;
         start_q  <= 1'b0;
         winner_q <= win_code(bus.zero1, bus.zero2);
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSE: begin
               if (go_ev) begin
                  state_q <= ST_RUN;
                  start_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (go_ev) begin
                  state_q <= ST_PAUSE;
                  start_q <= 1'b0;
               end else if (switch_d) begin
                  player_q <= ~player_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.start      = start_q;
   assign bus.player     = player_q;
   assign bus.winner     = winner_q;
   assign bus.game_state = state_q;

`ifdef CHESS_MOVE_CNT_EN
   logic [MOVE_W-1:0] moves_q;

   always_ff @(posedge clk_four) begin
      if (reset)
         moves_q <= '0;
      else if (switch_d && moves_q != {MOVE_W{1'b1}})
         moves_q <= moves_q + MOVE_W'(1);
   end

   assign bus.moves = moves_q;
`else
   assign bus.moves = {MOVE_W{1'b0}};
`endif

endmodule

// File: doc/chess_turn_ctrl.md
Name: chess_turn_ctrl

Overview:
Upstream control stage for the chess-clock timers. Conditions the raw player and start/pause push-buttons, runs the game state machine, and drives the shared `start` and `player` inputs of both countdown timers. Consumes the timers' `zero1`/`zero2` flags to end the game and declare a winner. Runs on the same `clk_four` domain as the timers, so there is no clock-domain crossing between this block and the timers.

Parameters:
- DEBOUNCE_CYC, 4: number of consecutive stable synchronised samples needed before a button level is accepted (range 1..255).
- MOVE_W, 6: width of the move counter (used only with the optional feature).

Ports:
- clk_four  input  1  timer clock; all logic is clocked on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_p1  input  1  raw asynchronous button: player 1 ends their turn.
- btn_p2  input  1  raw asynchronous button: player 2 ends their turn.
- btn_go  input  1  raw asynchronous button: start / pause / resume.
- zero1  input  1  player-1 timer expired.
- zero2  input  1  player-2 timer expired.
- start  output  1  timers count while this is high.
- player  output  1  active clock: 0 = player-1 timer runs, 1 = player-2 timer runs.
- winner  output  2  00 = none, 01 = player 1 wins, 10 = player 2 wins, 11 = draw.
- game_state  output  2  current FSM state (encoding below).
- moves  output  MOVE_W  accepted turn-switch count.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; start=0, player=0, winner=00, moves=0.
  - Synchroniser flops, debounce counters, debounced levels and edge registers all cleared.
  - Reset mid-game aborts immediately on that edge; no press events are generated for buttons held through reset.
- Button conditioning, per button, identical for all three:
  - 2-flop synchroniser.
  - Debounce counter: counts consecutive cycles in which the synchronised value differs from the debounced level. On reaching DEBOUNCE_CYC the debounced level flips and the counter clears. Any agreeing sample clears the counter.
  - Press event: one-cycle pulse on a debounced 0->1 transition. Release produces no event.
- Latency: a raw level held from edge n yields the event at edge n+2+DEBOUNCE_CYC. Registered outputs reflect it one edge later.
- FSM states: IDLE=00, RUN=01, PAUSE=10, OVER=11.
- IDLE:
  - start=0, player=0.
  - go event -> RUN.
  - p1/p2 events ignored.
- RUN:
  - start=1.
  - p1 event while player=0 -> player=1.
  - p2 event while player=1 -> player=0.
  - A press by the inactive player is ignored.
  - Simultaneous p1 and p2 events: only the active player's event is honoured.
  - go event -> PAUSE; player is held.
- PAUSE:
  - start=0, player held.
  - go event -> RUN.
  - p1/p2 events ignored.
- OVER:
  - start=0, player held.
  - Exit only via reset.
- Zero handling:
  - In RUN or PAUSE, zero1 or zero2 high forces OVER on that edge. This has priority over all button events in the same cycle.
  - winner is latched on entry to OVER: zero1 only -> 10, zero2 only -> 01, both -> 11.
  - zero inputs are ignored in IDLE and OVER.
- Same-cycle priority (highest first): reset, zero, go, turn switch. go and a turn event in the same cycle: go wins and the turn event is dropped.
- game_state equals the FSM register directly; all outputs are registered.

Optional Feature:
- Macro: CHESS_MOVE_CNT_EN.
- Defined:
  - moves increments by 1 on every honoured turn switch in RUN.
  - Saturates at 2^MOVE_W-1; no wrap.
  - Cleared only by reset.
- Undefined: the moves port remains and is tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package chess_pkg holds:
  - state localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_OVER;
  - winner codes WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW;
  - player codes PL_ONE=0, PL_TWO=1.
- One sub-module, btn_conditioner (synchroniser + debounce + rising-edge pulse, parameter DEBOUNCE_CYC), instantiated three times.

Test Plan:
- DEBOUNCE_CYC=2; reset, then hold btn_go high from edge 10 -> start=1 and game_state=01 first visible after edge 15; player=0.
- btn_go bounce: 1-cycle pulses on alternate cycles for 10 cycles -> no event; state stays IDLE.
- In RUN: press btn_p2 (inactive player) -> player stays 0. Then press btn_p1 -> player=1. Then press btn_p1 and btn_p2 together -> player=0. With CHESS_MOVE_CNT_EN, moves=2.
- In RUN, assert zero2 in the same cycle a go event fires -> OVER, winner=01, start=0. Subsequent button presses have no effect.
- In PAUSE, assert zero1 and zero2 together -> OVER, winner=11.
- Assert reset while in RUN with btn_p1 held -> IDLE, all outputs 0. After reset deasserts, no p1 event until the button is released and pressed again.
